e1_led_blinker_n: RTL

E1_LED_BLINKER_N -- requirements
Module: e1_led_blinker_n

---
 rtl/e1_led_pkg.sv | 27 ++
 rtl/e1_led_blinker_n_tick.sv | 33 +++
 rtl/e1_led_blinker_n.sv | 123 ++++++++++++
 3 files changed

// File: rtl/e1_led_pkg.sv
// rtl/e1_led_pkg.sv - shared mode codes, FSM states and LED decode helper
package e1_led_pkg;

  localparam logic [1:0] OFF  = 2'b00;
  localparam logic [1:0] ON   = 2'b01;
  localparam logic [1:0] SLOW = 2'b10;
  localparam logic [1:0] FAST = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GO   = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  function automatic logic led_bit(input logic [1:0] mode, input logic [3:0] phase);
    logic b;
    case (mode)
      OFF:     b = 1'b0;
      ON:      b = 1'b1;
      SLOW:    b = phase[3];
      FAST:    b = phase[1];
      default: b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/e1_led_blinker_n_tick.sv
// rtl/e1_led_blinker_n_tick.sv - free-running prescaler and 4-bit blink phase counter
module e1_led_tick #(
  parameter int unsigned TICK_LOG2_DIV = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       tick,
  output logic [3:0] phase
);

  logic [TICK_LOG2_DIV-1:0] presc_q, presc_d;
  logic [3:0]               phase_q, phase_d;

  // tick marks the last prescaler count, so phase advances on the wrap edge
  assign tick  = &presc_q;
  assign phase = phase_q;

  always_comb begin
    presc_d = presc_q + TICK_LOG2_DIV'(1);
    phase_d = tick ? phase_q + 4'd1 : phase_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      phase_q <= 4'd0;
    end else begin
      presc_q <= presc_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/e1_led_blinker_n.sv
// rtl/e1_led_blinker_n.sv - E1 port LED image generator with change/refresh driven shift-register sends
module e1_led_blinker_n
  import e1_led_pkg::*;
#(
  parameter  int unsigned N_PORTS       = 2,
  parameter  int unsigned TICK_LOG2_DIV = 20,
  parameter  int unsigned REFRESH_TICKS = 16,
  localparam int unsigned N_LED         = 2 * N_PORTS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2*N_LED-1:0]   led_state,
  input  logic                 en,
  output logic [N_LED-1:0]     sr_val,
  output logic                 sr_go,
  input  logic                 sr_rdy,
  output logic                 busy
);

  localparam logic [7:0] REFRESH_MAX = 8'(REFRESH_TICKS);

  logic             tick;
  logic [3:0]       phase;
  logic [N_LED-1:0] img;
  logic             refresh_due;

  state_e           state_q, state_d;
  logic [N_LED-1:0] sr_val_q, sr_val_d;
  logic [N_LED-1:0] last_q, last_d;
  logic             pend_q, pend_d;
  logic             wait_first_q, wait_first_d;
  logic [7:0]       rcnt_q, rcnt_d;

  e1_led_tick #(
    .TICK_LOG2_DIV(TICK_LOG2_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick),
    .phase(phase)
  );

  always_comb begin
    img = '0;
    if (en) begin
      for (int k = 0; k < N_LED; k++) begin
        img[k] = led_bit(led_state[2*k +: 2], phase);
      end
    end
  end

  assign refresh_due = (REFRESH_TICKS != 0) && (rcnt_q >= REFRESH_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (sr_rdy && ((img != last_q) || refresh_due || pend_q)) begin
          state_d = ST_GO;
        end
      end
      ST_GO:   state_d = ST_WAIT;
      // the first WAIT cycle ignores sr_rdy: the interface may not have registered the request yet
      ST_WAIT: begin
        if (!wait_first_q && sr_rdy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sr_go = (state_q == ST_GO);
    busy  = (state_q != ST_IDLE);
  end

  // the image is captured on entry to GO so sr_val is already valid while sr_go is high
  always_comb begin
    sr_val_d     = sr_val_q;
    last_d       = last_q;
    pend_d       = pend_q;
    wait_first_d = (state_q == ST_GO);
    rcnt_d       = rcnt_q;
    if (state_q == ST_IDLE && state_d == ST_GO) begin
      sr_val_d = img;
      last_d   = img;
    end
    if (state_q == ST_GO) begin
      pend_d = 1'b0;
      rcnt_d = 8'd0;
    end else if (tick && !refresh_due && rcnt_q != 8'hFF) begin
      rcnt_d = rcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_val_q     <= '0;
      last_q       <= '0;
      pend_q       <= 1'b1;
      wait_first_q <= 1'b0;
      rcnt_q       <= 8'd0;
    end else begin
      sr_val_q     <= sr_val_d;
      last_q       <= last_d;
      pend_q       <= pend_d;
      wait_first_q <= wait_first_d;
      rcnt_q       <= rcnt_d;
    end
  end

  assign sr_val = sr_val_q;

endmodule
